// File: rtl/volt_bcd_encoder.sv
`default_nettype none
// ============================================================================
// Module      : volt_bcd_encoder
// Description : Converts the held voltage sample (hundredths of a volt) into
//               X.YZ BCD digits once per refresh window, via a serial
//               double-dabble FSM. Optional macro: PEAK_HOLD_EN (window peak).
// Revision    : 1.0 - initial release
// ============================================================================
module volt_bcd_encoder #(
    parameter int DATA_W         = 12,
    parameter int REFRESH_CYCLES = 6000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    output logic [3:0]        integer_data,
    output logic [3:0]        float1_data,
    output logic [3:0]        float2_data,
    output logic              update,
    output logic              busy,
    output logic              over_range
);

    localparam int                c_TW      = $clog2(REFRESH_CYCLES);
    localparam logic [c_TW-1:0]   c_TICK_AT = c_TW'(REFRESH_CYCLES - 1);
    localparam logic [DATA_W-1:0] c_MAX     = DATA_W'(999);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_LOAD  = 2'd1;
    localparam logic [1:0] c_S_SHIFT = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    logic [c_TW-1:0]   r_timer;
    logic              w_tick;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_snap;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [9:0]        r_v;
    logic [11:0]       r_bcd;
    logic              r_ovf;
    logic [3:0]        r_cnt;
    logic [11:0]       w_adj;
    logic [11:0]       w_bcd_sh;
    logic [9:0]        w_v_sh;

    assign w_tick = (r_timer == c_TICK_AT);

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

`ifdef PEAK_HOLD_EN
    // Peak restarts at each tick; the tick-cycle sample seeds the next window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_tick) begin
            r_hold <= sample_valid ? sample : '0;
        end else if (sample_valid && (sample > r_hold)) begin
            r_hold <= sample;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (sample_valid) begin
            r_hold <= sample;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (w_tick) w_state_nxt = c_S_LOAD;
            c_S_LOAD:  w_state_nxt = c_S_SHIFT;
            c_S_SHIFT: if (r_cnt == 4'd9) w_state_nxt = c_S_DONE;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_adj[3:0]   = (r_bcd[3:0]   >= 4'd5) ? r_bcd[3:0]   + 4'd3 : r_bcd[3:0];
        w_adj[7:4]   = (r_bcd[7:4]   >= 4'd5) ? r_bcd[7:4]   + 4'd3 : r_bcd[7:4];
        w_adj[11:8]  = (r_bcd[11:8]  >= 4'd5) ? r_bcd[11:8]  + 4'd3 : r_bcd[11:8];
        {w_bcd_sh, w_v_sh} = {w_adj, r_v} << 1;
    end

    // Snapshot at the tick so a same-cycle sample lands in the next window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap       <= '0;
            r_v          <= '0;
            r_bcd        <= '0;
            r_ovf        <= 1'b0;
            r_cnt        <= '0;
            integer_data <= '0;
            float1_data  <= '0;
            float2_data  <= '0;
            over_range   <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_tick) r_snap <= r_hold;
                end
                c_S_LOAD: begin
                    r_v   <= (r_snap > c_MAX) ? 10'd999 : r_snap[9:0];
                    r_ovf <= (r_snap > c_MAX);
                    r_bcd <= '0;
                    r_cnt <= '0;
                end
                c_S_SHIFT: begin
                    r_bcd <= w_bcd_sh;
                    r_v   <= w_v_sh;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd9) begin
                        integer_data <= w_bcd_sh[11:8];
                        float1_data  <= w_bcd_sh[7:4];
                        float2_data  <= w_bcd_sh[3:0];
                        over_range   <= r_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state == c_S_LOAD) || (r_state == c_S_SHIFT);
    assign update = (r_state == c_S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_volt_bcd_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_volt_bcd_encoder
// Description : Directed self-checking bench for volt_bcd_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_volt_bcd_encoder;

    localparam int RC = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] sample = '0;
    logic        sample_valid = 1'b0;
    logic [3:0]  integer_data;
    logic [3:0]  float1_data;
    logic [3:0]  float2_data;
    logic        update;
    logic        busy;
    logic        over_range;

    int total = 0;
    int bad   = 0;
    int tb_cnt = 0;

    volt_bcd_encoder #(.DATA_W(12), .REFRESH_CYCLES(RC)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample),
        .sample_valid (sample_valid),
        .integer_data (integer_data),
        .float1_data  (float1_data),
        .float2_data  (float2_data),
        .update       (update),
        .busy         (busy),
        .over_range   (over_range)
    );

    always #5 clk = ~clk;

    // Window position: tick happens in the cycle where tb_cnt == RC-1.
    always @(posedge clk) begin
        if (rst) tb_cnt <= 0;
        else     tb_cnt <= (tb_cnt == RC - 1) ? 0 : tb_cnt + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic [11:0] v);
        sample       = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic goto_tick();
        int n;
        n = 0;
        @(negedge clk);
        while (tb_cnt != RC - 1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (n >= 80) chk("tick_timeout", tb_cnt, RC - 1);
    endtask

    task automatic run_window(input string tag, input logic tv, input logic [11:0] ts,
                              input int ei, input int ef1, input int ef2, input int eo);
        int busy_n;
        int upd_at;
        int both;
        busy_n = 0;
        upd_at = 0;
        both   = 0;
        goto_tick();
        sample       = ts;
        sample_valid = tv;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            if (busy) busy_n++;
            if (update && upd_at == 0) upd_at = k;
            if (busy && update) both = 1;
        end
        chk({tag, "_busy_cycles"}, busy_n, 11);
        chk({tag, "_update_at"}, upd_at, 12);
        chk({tag, "_busy_and_update"}, both, 0);
        chk({tag, "_integer"}, int'(integer_data), ei);
        chk({tag, "_float1"}, int'(float1_data), ef1);
        chk({tag, "_float2"}, int'(float2_data), ef2);
        chk({tag, "_over_range"}, int'(over_range), eo);
        @(negedge clk);
        chk({tag, "_update_drop"}, int'(update), 0);
    endtask

    initial begin
        int upd_seen;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_integer", int'(integer_data), 0);
        chk("rst_float1", int'(float1_data), 0);
        chk("rst_float2", int'(float2_data), 0);
        chk("rst_update", int'(update), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_over_range", int'(over_range), 0);
        rst = 1'b0;

        // No samples: zeros
        run_window("empty", 1'b0, 12'd0, 0, 0, 0, 0);

        // Single in-range sample
        pulse(12'd345);
        run_window("v345", 1'b0, 12'd0, 3, 4, 5, 0);

        // Over-range clamps, then recovers
        pulse(12'd1500);
        run_window("v1500", 1'b0, 12'd0, 9, 9, 9, 1);
        pulse(12'd7);
        run_window("v7", 1'b0, 12'd0, 0, 0, 7, 0);

        // Sample on the tick cycle belongs to the next window
`ifdef PEAK_HOLD_EN
        run_window("tick999", 1'b1, 12'd999, 0, 0, 0, 0);
`else
        run_window("tick999", 1'b1, 12'd999, 0, 0, 7, 0);
`endif
        run_window("tick512", 1'b1, 12'd512, 9, 9, 9, 0);
        run_window("after512", 1'b0, 12'd0, 5, 1, 2, 0);

        // Reset during SHIFT cycle 5 aborts the conversion
        pulse(12'd258);
        goto_tick();
        repeat (7) @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_integer", int'(integer_data), 0);
        chk("abort_float1", int'(float1_data), 0);
        chk("abort_float2", int'(float2_data), 0);
        chk("abort_over_range", int'(over_range), 0);
        chk("abort_update", int'(update), 0);
        rst = 1'b0;
        upd_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (update) upd_seen = 1;
        end
        chk("abort_no_update", upd_seen, 0);
        pulse(12'd258);
        run_window("post_abort", 1'b0, 12'd0, 2, 5, 8, 0);

        // Several samples in one window
        pulse(12'd120);
        pulse(12'd870);
        pulse(12'd40);
`ifdef PEAK_HOLD_EN
        run_window("multi", 1'b0, 12'd0, 8, 7, 0, 0);
`else
        run_window("multi", 1'b0, 12'd0, 0, 4, 0, 0);
`endif
        pulse(12'd40);
        run_window("only40", 1'b0, 12'd0, 0, 4, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
